// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : ultrasonic_ranger
// Description : Drives the trigger pulse of an ultrasonic range sensor and
//               measures the width of the returned echo pulse in clk cycles.
//               Measurements repeat every MEAS_PERIOD cycles while enable is
//               high. Missing and over-long echoes are reported on timeout.
// Ports       : clk          - single clock, rising edge
//               reset        - synchronous, active-high
//               enable       - permits the start of new measurements
//               echo         - asynchronous echo from the sensor
//               trig         - sensor trigger pulse
//               dist_counter - last valid echo width in clk cycles
//               dist_valid   - one-cycle strobe when dist_counter updates
//               timeout      - high while the last measurement failed
// Revision    : 1.0 - initial release
// ============================================================================
module ultrasonic_ranger #(
    parameter int TRIG_CYCLES  = 500,
    parameter int ECHO_TIMEOUT = 1_000_000,
    parameter int MEAS_PERIOD  = 3_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        echo,
    output logic        trig,
    output logic [25:0] dist_counter,
    output logic        dist_valid,
    output logic        timeout
);

    // The period counter only needs to reach MEAS_PERIOD-1.
    localparam int              c_PW          = $clog2(MEAS_PERIOD);
    localparam logic [c_PW-1:0] c_PERIOD_LAST = c_PW'(MEAS_PERIOD - 1);
    localparam logic [c_PW-1:0] c_PERIOD_ONE  = c_PW'(1);
    localparam logic [25:0]     c_TRIG_LAST   = 26'(TRIG_CYCLES - 1);
    localparam logic [25:0]     c_ECHO_LAST   = 26'(ECHO_TIMEOUT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TRIG      = 3'd1;
    localparam logic [2:0] c_WAIT_RISE = 3'd2;
    localparam logic [2:0] c_MEASURE   = 3'd3;
    localparam logic [2:0] c_HOLDOFF   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic            r_echo_meta;
    logic            r_echo_s;
    logic            r_echo_d;
    logic            w_rise;
    logic [25:0]     r_cnt;      // trigger length, rise wait, or echo width
    logic [c_PW-1:0] r_period;
    logic            r_trig;
    logic [25:0]     r_dist;
    logic            r_valid;
    logic            r_timeout;
    logic            w_trig;
    logic            w_done;
    logic            w_fail;

    // ------------------------------------------------------------------
    // Echo synchronizer and rising-edge detect. Using the delayed copy
    // means an echo already high when WAIT_RISE is entered never counts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
            r_echo_d    <= 1'b0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
            r_echo_d    <= r_echo_s;
        end
    end

    assign w_rise = r_echo_s & ~r_echo_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable) w_next = c_TRIG;
            end
            c_TRIG: begin
                if (r_cnt == c_TRIG_LAST) w_next = c_WAIT_RISE;
            end
            c_WAIT_RISE: begin
                if (w_rise)                    w_next = c_MEASURE;
                else if (r_cnt == c_ECHO_LAST) w_next = c_HOLDOFF;
            end
            c_MEASURE: begin
                // r_cnt is the width so far; one more high cycle would
                // reach ECHO_TIMEOUT, which is treated as a failure.
                if (!r_echo_s)                 w_next = c_HOLDOFF;
                else if (r_cnt == c_ECHO_LAST) w_next = c_HOLDOFF;
            end
            c_HOLDOFF: begin
                if (r_period == c_PERIOD_LAST) w_next = enable ? c_TRIG : c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_trig = 1'b0;
        w_done = 1'b0;
        w_fail = 1'b0;
        case (r_state)
            c_TRIG:      w_trig = 1'b1;
            c_WAIT_RISE: w_fail = !w_rise && (r_cnt == c_ECHO_LAST);
            c_MEASURE: begin
                w_done = !r_echo_s;
                w_fail = r_echo_s && (r_cnt == c_ECHO_LAST);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared cycle counter: cleared on every state change, except that the
    // rise cycle itself already counts as echo width 1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= (w_next == c_MEASURE) ? 26'd1 : 26'd0;
        end else if (r_state == c_TRIG || r_state == c_WAIT_RISE ||
                     r_state == c_MEASURE) begin
            r_cnt <= r_cnt + 26'd1;
        end
    end

    // Period counter restarts on each TRIG entry and saturates at the end
    // of the period, so trigger starts are exactly MEAS_PERIOD apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period <= '0;
        end else if (w_next == c_TRIG && r_state != c_TRIG) begin
            r_period <= '0;
        end else if (r_period != c_PERIOD_LAST) begin
            r_period <= r_period + c_PERIOD_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs. trig lags the TRIG state by one cycle, giving a
    // glitch-free pulse of exactly TRIG_CYCLES cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trig    <= 1'b0;
            r_dist    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_trig  <= w_trig;
            r_valid <= w_done;
            if (w_done) begin
                r_dist    <= r_cnt;
                r_timeout <= 1'b0;
            end else if (w_fail) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign trig         = r_trig;
    assign dist_counter = r_dist;
    assign dist_valid   = r_valid;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ============================================================================
// Module      : tb_ultrasonic_ranger
// Description : Self-checking bench for ultrasonic_ranger with small
//               parameters. Expected widths are queued when an echo is
//               driven and compared when dist_valid strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ultrasonic_ranger;

    localparam int c_TRIG   = 10;
    localparam int c_TO     = 200;
    localparam int c_PERIOD = 500;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        echo;
    logic        trig;
    logic [25:0] dist_counter;
    logic        dist_valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [25:0] exp_q[$];
    int          rises[$];
    logic        trig_prev = 1'b0;

    ultrasonic_ranger #(
        .TRIG_CYCLES (c_TRIG),
        .ECHO_TIMEOUT(c_TO),
        .MEAS_PERIOD (c_PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .echo        (echo),
        .trig        (trig),
        .dist_counter(dist_counter),
        .dist_valid  (dist_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every dist_valid strobe must match the oldest queued width.
    always @(negedge clk) begin
        if (!reset && dist_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dist_valid", 32'(dist_counter), 32'hFFFF_FFFF);
            end else begin
                check("scoreboard_dist", 32'(dist_counter), 32'(exp_q.pop_front()));
            end
        end
        if (trig === 1'b1 && trig_prev === 1'b0) rises.push_back(cyc);
        trig_prev = trig;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(input string tag, input logic val);
        int k = 0;
        while (trig !== val && k < 600) begin
            tick(1);
            k++;
        end
        check(tag, 32'(trig), 32'(val));
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        do begin
            tick(1);
            k++;
        end while (dist_valid !== 1'b1 && k < 10);
        check({tag, "_latency_2to3"}, 32'(k >= 2 && k <= 3), 32'd1);
        check({tag, "_timeout_clear"}, 32'(timeout), 32'd0);
        tick(1);
        check({tag, "_single_pulse"}, 32'(dist_valid), 32'd0);
    endtask

    // Checks timeout rises exactly 200 cycles after WAIT_RISE entry, which
    // is one cycle before the first sample with trig low.
    task automatic check_timeout_edge(input string tag);
        tick(c_TO - 2);
        check({tag, "_timeout_before"}, 32'(timeout), 32'd0);
        tick(1);
        check({tag, "_timeout_at"}, 32'(timeout), 32'd1);
    endtask

    initial begin
        int width;
        int highs;
        reset  = 1'b1;
        enable = 1'b1;
        echo   = 1'b0;
        tick(3);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_dist", 32'(dist_counter), 32'd0);
        check("rst_valid", 32'(dist_valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // M1: trig on the 2nd edge after reset release, normal 57-cycle echo
        reset = 1'b0;
        tick(1);
        check("m1_trig_edge1", 32'(trig), 32'd0);
        tick(1);
        check("m1_trig_edge2", 32'(trig), 32'd1);
        width = 0;
        while (trig === 1'b1 && width < 50) begin
            width++;
            tick(1);
        end
        check("m1_trig_width", 32'(width), 32'(c_TRIG));
        tick(19);
        exp_q.push_back(26'd57);
        echo = 1'b1;
        tick(57);
        echo = 1'b0;
        wait_valid("m1");
        check("m1_dist", 32'(dist_counter), 32'd57);

        // M2: echo stuck high through the trigger -> no measurement, timeout
        echo = 1'b1;
        wait_trig("m2_trig_rise", 1'b1);
        wait_trig("m2_trig_fall", 1'b0);
        check_timeout_edge("m2");
        check("m2_dist_hold", 32'(dist_counter), 32'd57);
        echo = 1'b0;

        // M3: single-cycle echo gives width 1 and clears timeout
        wait_trig("m3_trig_rise", 1'b1);
        wait_trig("m3_trig_fall", 1'b0);
        tick(5);
        exp_q.push_back(26'd1);
        echo = 1'b1;
        tick(1);
        echo = 1'b0;
        wait_valid("m3");
        check("m3_dist", 32'(dist_counter), 32'd1);

        // M4: no echo at all
        wait_trig("m4_trig_rise", 1'b1);
        wait_trig("m4_trig_fall", 1'b0);
        check_timeout_edge("m4");
        check("m4_dist_hold", 32'(dist_counter), 32'd1);

        // M5: normal 40-cycle echo
        wait_trig("m5_trig_rise", 1'b1);
        wait_trig("m5_trig_fall", 1'b0);
        tick(8);
        exp_q.push_back(26'd40);
        echo = 1'b1;
        tick(40);
        echo = 1'b0;
        wait_valid("m5");
        check("m5_dist", 32'(dist_counter), 32'd40);

        // M6: 300-cycle echo, timeout when the width reaches 200
        wait_trig("m6_trig_rise", 1'b1);
        wait_trig("m6_trig_fall", 1'b0);
        tick(10);
        echo = 1'b1;
        tick(c_TO + 1);
        check("m6_timeout_before", 32'(timeout), 32'd0);
        tick(1);
        check("m6_timeout_at", 32'(timeout), 32'd1);
        tick(98);
        echo = 1'b0;
        tick(10);
        check("m6_dist_hold", 32'(dist_counter), 32'd40);

        // M7: enable dropped mid-measurement completes, then parks in IDLE
        wait_trig("m7_trig_rise", 1'b1);
        wait_trig("m7_trig_fall", 1'b0);
        tick(5);
        exp_q.push_back(26'd30);
        echo = 1'b1;
        tick(10);
        enable = 1'b0;
        tick(20);
        echo = 1'b0;
        wait_valid("m7");
        check("m7_dist", 32'(dist_counter), 32'd30);
        highs = 0;
        for (int i = 0; i < 700; i++) begin
            tick(1);
            if (trig === 1'b1) highs++;
        end
        check("m7_parked_no_trig", 32'(highs), 32'd0);
        enable = 1'b1;
        tick(1);
        check("m7_reenable_edge1", 32'(trig), 32'd0);
        tick(1);
        check("m7_reenable_edge2", 32'(trig), 32'd1);

        // M8: reset in the middle of a measurement
        wait_trig("m8_trig_fall", 1'b0);
        tick(5);
        echo = 1'b1;
        tick(32);
        reset = 1'b1;
        tick(1);
        check("m8_rst_trig", 32'(trig), 32'd0);
        check("m8_rst_dist", 32'(dist_counter), 32'd0);
        check("m8_rst_valid", 32'(dist_valid), 32'd0);
        check("m8_rst_timeout", 32'(timeout), 32'd0);
        echo = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("m8_trig_edge1", 32'(trig), 32'd0);
        tick(1);
        check("m8_trig_edge2", 32'(trig), 32'd1);
        wait_trig("m8_trig_fall2", 1'b0);
        tick(20);

        check("trig_rise_count", 32'(rises.size()), 32'd9);
        for (int i = 0; i < 6; i++) begin
            check("trig_period", 32'(rises[i+1] - rises[i]), 32'(c_PERIOD));
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ultrasonic_ranger.md
ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 Parameter TRIG_CYCLES, default 500, sets the trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 Parameter ECHO_TIMEOUT, default 1_000_000, sets the max cycles allowed for echo rise wait and for echo width.
REQ-003 Parameter MEAS_PERIOD, default 3_000_000, sets the cycles from one trigger start to the next; MEAS_PERIOD >= TRIG_CYCLES + 2*ECHO_TIMEOUT + 8 SHALL hold.
REQ-004 Port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: permits the start of new measurements.
REQ-007 Port echo, input, 1 bit: asynchronous sensor echo.
REQ-008 Port trig, output, 1 bit: sensor trigger pulse.
REQ-009 Port dist_counter, output, 26 bits: last valid echo width in clk cycles; drives the LED bar controller.
REQ-010 Port dist_valid, output, 1 bit: one-cycle strobe when dist_counter updates.
REQ-011 Port timeout, output, 1 bit: high while the last measurement failed.

Function
REQ-012 echo SHALL pass through a 2-flop synchronizer (echo_s); edge detection SHALL use echo_s and its 1-cycle delayed copy.
REQ-013 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
REQ-014 IDLE: with enable=1, go to TRIG next cycle; otherwise stay.
REQ-015 Entering TRIG SHALL clear the period counter, which increments every cycle until MEAS_PERIOD-1 is reached.
REQ-016 TRIG: trig=1 for exactly TRIG_CYCLES consecutive cycles, then go to WAIT_RISE; trig=0 in all other states.
REQ-017 WAIT_RISE: an echo_s rising edge moves to MEASURE with that cycle counted as width 1; an echo_s already high on entry SHALL NOT count as a rise.
REQ-018 WAIT_RISE: after ECHO_TIMEOUT cycles with no rise, set timeout=1, leave dist_counter unchanged, and go to HOLDOFF.
REQ-019 MEASURE: the width counter increments each cycle echo_s=1.
REQ-020 MEASURE: on echo_s=0, latch width into dist_counter, pulse dist_valid for 1 cycle, clear timeout, and go to HOLDOFF.
REQ-021 MEASURE: if width reaches ECHO_TIMEOUT while echo_s=1, set timeout=1, leave dist_counter unchanged, give no dist_valid, and go to HOLDOFF.
REQ-022 HOLDOFF: when the period counter = MEAS_PERIOD-1, go to TRIG if enable=1, else IDLE.
REQ-023 Trigger starts SHALL therefore be exactly MEAS_PERIOD cycles apart while enable stays 1.
REQ-024 Dropping enable SHALL NOT abort a measurement in progress; it only blocks the next trigger.
REQ-025 Width counter: 26 bits; it never wraps, because ECHO_TIMEOUT < 2^26 SHALL hold.
REQ-026 Echo glitches shorter than 1 cycle after sync SHALL have no special filtering; a 1-cycle echo_s pulse gives dist_counter=1.

Reset
REQ-027 reset=1 SHALL force IDLE, trig=0, dist_counter=0, dist_valid=0, timeout=0, all counters=0, and synchronizer flops=0.
REQ-028 reset asserted mid-TRIG or mid-MEASURE SHALL drop trig the next cycle and discard the partial width.
REQ-029 After reset deasserts with enable=1, trig SHALL rise on the 2nd clk edge (IDLE->TRIG, then TRIG output).

Verification (TRIG_CYCLES=10, ECHO_TIMEOUT=200, MEAS_PERIOD=500)
REQ-030 Normal: echo high 57 cycles starting 20 cycles after trig falls -> trig high 10 cycles; dist_counter=57 with one dist_valid pulse 2-3 cycles after echo falls; timeout=0.
REQ-031 No echo -> timeout=1 exactly 200 cycles after WAIT_RISE entry; dist_counter holds its prior value; next trig starts 500 cycles after the previous one.
REQ-032 Stuck echo: echo held high before and through the trigger -> no MEASURE entry, timeout=1.
REQ-033 Over-long echo: echo high 300 cycles -> timeout=1 at width 200; no dist_valid; dist_counter unchanged.
REQ-034 Reset mid-MEASURE (after 30 echo cycles) -> all outputs 0 next cycle; a fresh trig follows per REQ-029.
REQ-035 enable dropped during MEASURE -> the measurement completes with dist_valid; FSM then parks in IDLE with no further trig until enable=1.
